agg_lane_serializer: RTL and testbench
======================================

# agg_lane_serializer

Downstream stage of the case-selected aggregate output: captures one 3-lane × 3-bit aggregate word, plus the select tag that chose it, in a single cycle. It then emits the lanes one per beat over a valid/ready stream, so a narrow consumer can take the three lane values without a wide bus. A frame counter records completed transfers for debug.

## Interface
Parameters:
- LANES, 3, number of lanes per aggregate (≥2)
- WIDTH, 3, bits per lane
- CNT_W, 8, frame counter width

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  aggregate word available
- in_ready  output  1  block accepts aggregate this cycle
- in_data  input  LANES*WIDTH  lane i at bits [i*WIDTH +: WIDTH]; lane 0 is the upstream out_0
- in_tag  input  1  upstream select state captured with the word
- out_valid  output  1  lane beat valid
- out_ready  input  1  consumer accepts beat
- out_data  output  WIDTH  current lane value
- out_idx  output  $clog2(LANES)  index of current lane
- out_last  output  1  high on lane LANES-1 beat
- out_tag  output  1  tag of frame being sent
- frame_cnt  output  CNT_W  count of fully sent frames

## Operation
- States: IDLE, SEND.
- IDLE:
  - in_ready=1.
  - On in_valid, capture in_data and in_tag into the holding register, set lane index to 0, and go to SEND.
- SEND:
  - out_valid=1; out_data = held lane[idx].
  - Beat completes on out_valid && out_ready; idx increments.
  - On the last beat (idx==LANES-1) completing:
    - frame_cnt increments, wrapping 2^CNT_W-1 → 0.
    - If in_valid is also high, capture the new word, set idx=0, and stay in SEND (back-to-back; no bubble).
    - Otherwise go to IDLE.
- in_ready = IDLE || (SEND && idx==LANES-1 && out_ready).
- Holding register is written only on an in handshake. The data/tag of a frame never changes mid-frame.
- out_last = SEND && idx==LANES-1.
- Outputs must be stable while out_valid && !out_ready. idx does not advance without a handshake.
- in_tag is carried unmodified. No arithmetic on lane data.

## Timing
- Reset values:
  - state=IDLE, out_valid=0, out_data=0, out_idx=0, out_last=0, out_tag=0, frame_cnt=0.
  - in_ready=1 on the first cycle after reset deasserts.
- Latency: first beat presents out_valid one cycle after the in handshake.
- Throughput: LANES cycles per frame with out_ready held high, including back-to-back frames.
- in_ready has a combinational path from out_ready in SEND. No other combinational in→out paths.
- Reset mid-frame: the frame is abandoned and frame_cnt is not incremented. The next cycle behaves as post-reset.
- in_valid while SEND and not on a completing last beat: ignored (in_ready=0). Upstream must hold.
- out_ready toggling mid-frame: beats stall; lane order is always 0..LANES-1, with no skips or repeats.

## Structure
- Shared package:
  - state enum {IDLE, SEND}
  - IDX_W = $clog2(LANES) helper
  - default LANES/WIDTH constants matching the aggregate producer
- Single flat module. The lane mux is a simple indexed slice, so no sub-module is needed.

## Test plan
- Reset, then in_data=9'b101_010_001, tag=1, out_ready=1:
  - out_data 1,2,5 on consecutive cycles; idx 0,1,2; out_last only on the third beat; out_tag=1; frame_cnt 0→1.
- Two frames offered back-to-back (in_valid held, second word 9'b111_000_011):
  - 6 beats with no gap: 1,2,5,3,0,7.
  - in_ready high only on the IDLE cycle and the last-beat cycle.
- out_ready low for 3 cycles at lane 1:
  - out_data=2 and out_idx=1 held stable throughout.
  - A change on in_data during the stall does not affect output.
- rst asserted during lane 1:
  - Next cycle out_valid=0 and frame_cnt unchanged (0).
  - A new frame then sends from lane 0.
- 256 frames with CNT_W=8: frame_cnt wraps to 0 after the 256th last beat.
- Random valid/ready backpressure over 1000 frames: scoreboard matches lane order, data and tag exactly.

Source files
------------

// File: rtl/agg_lane_serializer_pkg.sv
// -----------------------------------------------------------------------------
// agg_lane_serializer_pkg
//   Shared types and constants for the aggregate lane serializer.
//   - state_t      : serializer FSM state (IDLE, SEND)
//   - DEFAULT_*    : lane geometry matching the upstream aggregate producer
//   - idx_width()  : width of a lane index for a given lane count
// -----------------------------------------------------------------------------
package agg_lane_serializer_pkg;

    localparam int DEFAULT_LANES = 3;
    localparam int DEFAULT_WIDTH = 3;
    localparam int DEFAULT_CNT_W = 8;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    function automatic int idx_width(input int lanes);
        return $clog2(lanes);
    endfunction

endpackage

// File: rtl/agg_lane_serializer.sv
// -----------------------------------------------------------------------------
// agg_lane_serializer
//   Captures one LANES x WIDTH aggregate word plus its select tag in a single
//   cycle, then emits the lanes one per beat (lane 0 first) over a valid/ready
//   stream. A wrapping frame counter records completed frames for debug.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   in_valid   aggregate word available
//   in_ready   block accepts an aggregate this cycle
//   in_data    lane i at bits [i*WIDTH +: WIDTH]
//   in_tag     upstream select state captured with the word
//   out_valid  lane beat valid
//   out_ready  consumer accepts beat
//   out_data   current lane value
//   out_idx    index of current lane
//   out_last   high on the final lane beat
//   out_tag    tag of the frame being sent
//   frame_cnt  count of fully sent frames (wraps)
// -----------------------------------------------------------------------------
module agg_lane_serializer
    import agg_lane_serializer_pkg::*;
#(
    parameter int LANES = DEFAULT_LANES,
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = DEFAULT_CNT_W
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [LANES*WIDTH-1:0]       in_data,
    input  logic                         in_tag,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [WIDTH-1:0]             out_data,
    output logic [idx_width(LANES)-1:0]  out_idx,
    output logic                         out_last,
    output logic                         out_tag,
    output logic [CNT_W-1:0]             frame_cnt
);

    localparam int                IDX_W    = idx_width(LANES);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(LANES - 1);

    state_t                         state;
    state_t                         state_n;
    logic [LANES-1:0][WIDTH-1:0]    hold_data;
    logic                           hold_tag;
    logic [IDX_W-1:0]               idx;
    logic                           beat;
    logic                           last_beat;
    logic                           in_hs;

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: registered state always uses non-blocking assignment so every
        // flop samples the pre-edge value of every other flop.
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next state and handshake outputs. in_ready opens on the completing last
    // beat so a new word can be taken in the same cycle the old frame ends.
    always_comb begin
        // NOTE: everything assigned here gets a default first, so no branch
        // can leave a signal unassigned and infer a latch.
        state_n   = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_last  = 1'b0;
        beat      = 1'b0;
        last_beat = 1'b0;

        unique case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_n = SEND;
                end
            end
            SEND: begin
                out_valid = 1'b1;
                out_last  = (idx == LAST_IDX);
                beat      = out_ready;
                last_beat = out_ready && (idx == LAST_IDX);
                in_ready  = last_beat;
                if (last_beat && !in_valid) begin
                    state_n = IDLE;
                end
            end
        endcase
    end

    assign in_hs = in_valid && in_ready;

    // Holding register, lane index and frame counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the holding register is a few flops, not a memory array,
            // so it is reset to keep out_data/out_tag free of X after reset.
            hold_data <= '0;
            hold_tag  <= 1'b0;
            idx       <= '0;
            frame_cnt <= '0;
        end else begin
            if (in_hs) begin
                hold_data <= in_data;
                hold_tag  <= in_tag;
                idx       <= '0;
            end else if (beat) begin
                idx <= last_beat ? '0 : idx + IDX_W'(1);
            end

            if (last_beat) begin
                frame_cnt <= frame_cnt + CNT_W'(1);
            end
        end
    end

    // Outputs read zero outside SEND so IDLE never shows a stale lane.
    assign out_data = (state == SEND) ? hold_data[idx] : '0;
    assign out_tag  = (state == SEND) ? hold_tag : 1'b0;
    assign out_idx  = idx;

endmodule

// File: tb/tb_agg_lane_serializer.sv
module tb_agg_lane_serializer;

    localparam int LANES = 3;
    localparam int WIDTH = 3;
    localparam int CNT_W = 8;

    logic                     clk;
    logic                     rst;
    logic                     in_valid;
    logic                     in_ready;
    logic [LANES*WIDTH-1:0]   in_data;
    logic                     in_tag;
    logic                     out_valid;
    logic                     out_ready;
    logic [WIDTH-1:0]         out_data;
    logic [1:0]               out_idx;
    logic                     out_last;
    logic                     out_tag;
    logic [CNT_W-1:0]         frame_cnt;

    agg_lane_serializer #(
        .LANES (LANES),
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .out_tag   (out_tag),
        .frame_cnt (frame_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One table row is one clock cycle: inputs driven, then the outputs seen
    // before the next rising edge.
    typedef struct {
        logic        r;
        logic        iv;
        logic [8:0]  d;
        logic        t;
        logic        ordy;
        logic        e_ir;
        logic        e_ov;
        logic [2:0]  e_od;
        logic [1:0]  e_oi;
        logic        e_ol;
        logic        e_ot;
        logic [7:0]  e_fc;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic iv, input logic [8:0] d, input logic t,
                       input logic ordy, input logic e_ir, input logic e_ov,
                       input logic [2:0] e_od, input logic [1:0] e_oi, input logic e_ol,
                       input logic e_ot, input logic [7:0] e_fc);
        vec_t v;
        v.r = r; v.iv = iv; v.d = d; v.t = t; v.ordy = ordy;
        v.e_ir = e_ir; v.e_ov = e_ov; v.e_od = e_od; v.e_oi = e_oi;
        v.e_ol = e_ol; v.e_ot = e_ot; v.e_fc = e_fc;
        vecs.push_back(v);
    endtask

    function automatic logic [31:0] pack_obs(input logic ir, input logic ov, input logic [2:0] od,
                                             input logic [1:0] oi, input logic ol, input logic ot,
                                             input logic [7:0] fc);
        return {15'd0, ir, ov, od, oi, ol, ot, fc};
    endfunction

    // Leaves the bench at posedge+1 with reset released.
    task automatic do_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_tag    = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    typedef struct {
        logic [8:0] d;
        logic       t;
    } word_t;

    initial begin
        word_t       q[$];
        word_t       w;
        logic        hs_prev;
        int          sent;
        int          got;
        int          lane;
        int          cyc;
        logic [31:0] exp_beat;

        // ---- Frame A: single frame, out_ready high ----
        add(0,1,9'h151,1,1, 1,0,0,0,0,0,0);
        add(0,0,9'h151,1,1, 0,1,1,0,0,1,0);
        add(0,0,9'h151,1,1, 0,1,2,1,0,1,0);
        add(0,0,9'h151,1,1, 1,1,5,2,1,1,0);
        add(0,0,9'h151,1,1, 1,0,0,0,0,0,1);
        // ---- B: back-to-back frames, in_valid held ----
        add(0,1,9'h151,0,1, 1,0,0,0,0,0,1);
        add(0,1,9'h1C3,1,1, 0,1,1,0,0,0,1);
        add(0,1,9'h1C3,1,1, 0,1,2,1,0,0,1);
        add(0,1,9'h1C3,1,1, 1,1,5,2,1,0,1);
        add(0,0,9'h000,0,1, 0,1,3,0,0,1,2);
        add(0,0,9'h000,0,1, 0,1,0,1,0,1,2);
        add(0,0,9'h000,0,1, 1,1,7,2,1,1,2);
        add(0,0,9'h000,0,1, 1,0,0,0,0,0,3);
        // ---- C: stall at lane 1, in_data changes while stalled ----
        add(0,1,9'h151,1,1, 1,0,0,0,0,0,3);
        add(0,0,9'h151,1,1, 0,1,1,0,0,1,3);
        add(0,0,9'h151,1,0, 0,1,2,1,0,1,3);
        add(0,0,9'h0AA,0,0, 0,1,2,1,0,1,3);
        add(0,1,9'h1FF,0,0, 0,1,2,1,0,1,3);
        add(0,0,9'h0AA,0,1, 0,1,2,1,0,1,3);
        add(0,0,9'h0AA,0,0, 0,1,5,2,1,1,3);
        add(0,0,9'h000,0,1, 1,1,5,2,1,1,3);
        add(0,0,9'h000,0,1, 1,0,0,0,0,0,4);
        // ---- D: reset during lane 1, then a fresh frame ----
        add(0,1,9'h1C3,0,1, 1,0,0,0,0,0,4);
        add(0,0,9'h1C3,0,1, 0,1,3,0,0,0,4);
        add(1,0,9'h1C3,0,1, 0,1,0,1,0,0,4);
        add(0,1,9'h151,1,1, 1,0,0,0,0,0,0);
        add(0,0,9'h000,0,1, 0,1,1,0,0,1,0);
        add(0,0,9'h000,0,1, 0,1,2,1,0,1,0);
        add(0,0,9'h000,0,1, 1,1,5,2,1,1,0);
        add(0,0,9'h000,0,1, 1,0,0,0,0,0,1);

        do_reset();
        #1;
        check("reset_state", pack_obs(in_ready, out_valid, out_data, out_idx, out_last, out_tag, frame_cnt),
              pack_obs(1'b1, 1'b0, 3'd0, 2'd0, 1'b0, 1'b0, 8'd0));
        @(posedge clk);
        #1;

        for (int i = 0; i < vecs.size(); i++) begin
            rst       = vecs[i].r;
            in_valid  = vecs[i].iv;
            in_data   = vecs[i].d;
            in_tag    = vecs[i].t;
            out_ready = vecs[i].ordy;
            #1;
            check($sformatf("row%0d", i),
                  pack_obs(in_ready, out_valid, out_data, out_idx, out_last, out_tag, frame_cnt),
                  pack_obs(vecs[i].e_ir, vecs[i].e_ov, vecs[i].e_od, vecs[i].e_oi,
                           vecs[i].e_ol, vecs[i].e_ot, vecs[i].e_fc));
            @(posedge clk);
            #1;
        end

        // ---- 256 back-to-back frames: frame_cnt wraps to 0 ----
        do_reset();
        in_valid  = 1'b1;
        in_data   = 9'h0D5;
        in_tag    = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);                 // frame 1 captured
        repeat (765) @(posedge clk);    // 255 frames completed
        #1;
        check("wrap_cnt_255", {24'd0, frame_cnt}, 32'd255);
        repeat (2) @(posedge clk);
        #1;
        check("wrap_last_beat", {30'd0, out_valid, out_last}, 32'd3);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("wrap_cnt_0", {23'd0, out_valid, frame_cnt}, 32'd0);

        // ---- Random backpressure, 1000 frames, scoreboard ----
        do_reset();
        hs_prev = 1'b0;
        sent    = 0;
        got     = 0;
        lane    = 0;
        cyc     = 0;
        while (got < 1000 && cyc < 20000) begin
            if (hs_prev) in_valid = 1'b0;
            if (!in_valid && sent < 1000 && $urandom_range(0, 3) != 0) begin
                in_data  = 9'($urandom);
                in_tag   = 1'($urandom);
                in_valid = 1'b1;
            end
            out_ready = ($urandom_range(0, 2) != 0);
            #3;
            hs_prev = in_valid && in_ready;
            if (hs_prev) begin
                w.d = in_data;
                w.t = in_tag;
                q.push_back(w);
                sent++;
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    check("rand_beat_without_frame", 32'd1, 32'd0);
                end else begin
                    w = q[0];
                    exp_beat = {25'd0, w.d[lane*WIDTH +: WIDTH], 2'(lane), (lane == LANES-1), w.t};
                    check($sformatf("rand_beat_f%0d_l%0d", got, lane),
                          {25'd0, out_data, out_idx, out_last, out_tag}, exp_beat);
                    if (lane == LANES-1) begin
                        lane = 0;
                        void'(q.pop_front());
                        got++;
                    end else begin
                        lane++;
                    end
                end
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        check("rand_frames_done", got, 1000);
        check("rand_queue_empty", q.size(), 0);
        check("rand_frame_cnt", {24'd0, frame_cnt}, 32'(1000 % 256));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
